period_meter: RTL and testbench

- Sits directly downstream of the variable clock divider. Consumes the divider's registered output, which is synchronous to the same clk.
- Measures the high time, low time and period of each complete cycle of that signal, counted in clk cycles.
- Publishes each measurement with a one-cycle valid strobe.
- Flags a stuck or too-slow input with a sticky timeout bit.
- Used for self-check of divider settings and as a frequency readout.

---
 rtl/period_meter_pkg.sv | 18 +
 rtl/period_meter_edge_detect.sv | 28 ++
 rtl/period_meter.sv | 144 ++++++++++++++
 tb/tb_period_meter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: state encoding, default counter
// width and the phase-length limit that triggers a timeout.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

  // Longest phase a CNT_W-bit counter can hold: 2^w - 1 cycles.
  function automatic int timeout_limit(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/period_meter_edge_detect.sv
// Registers the incoming divided signal and flags single-cycle rise/fall
// events. The register resets to 1 so a signal that is already high when
// reset is released is never mistaken for a rising edge.
module edge_detect
  import period_meter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // Delay sig_in by one clock to compare against the current sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 1'b1;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q;
  assign fall = ~sig_in & sig_q;

endmodule

// File: rtl/period_meter.sv
// Measures high time, low time and period of a clk-synchronous divided
// signal in clk cycles. A measurement is published with a one-cycle strobe
// each time a rise closes a complete high+low cycle. A phase that outlasts
// the counter range sets a sticky timeout and restarts from IDLE.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             clear,
  output logic             meas_valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(timeout_limit(CNT_W));
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic             rise;
  logic             fall;

  state_t           state, state_next;
  logic [CNT_W-1:0] hi, hi_next;
  logic [CNT_W-1:0] lo, lo_next;
  logic             meas_valid_next;
  logic [CNT_W-1:0] high_cnt_next;
  logic [CNT_W-1:0] low_cnt_next;
  logic [CNT_W:0]   period_next;
  logic             timeout_next;

  edge_detect u_edge_detect (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_in  (sig_in),
    .rise    (rise),
    .fall    (fall)
  );

  // State, phase counters and published outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hi         <= '0;
      lo         <= '0;
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period     <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      hi         <= hi_next;
      lo         <= lo_next;
      meas_valid <= meas_valid_next;
      high_cnt   <= high_cnt_next;
      low_cnt    <= low_cnt_next;
      period     <= period_next;
      timeout    <= timeout_next;
    end
  end

  // Next-state logic: count phases, publish on the closing rise, and fall
  // back to IDLE on clear (highest priority) or counter overflow.
  always_comb begin
    state_next      = state;
    hi_next         = hi;
    lo_next         = lo;
    meas_valid_next = 1'b0;
    high_cnt_next   = high_cnt;
    low_cnt_next    = low_cnt;
    period_next     = period;
    timeout_next    = timeout;

    if (clear) begin
      state_next    = IDLE;
      hi_next       = '0;
      lo_next       = '0;
      high_cnt_next = '0;
      low_cnt_next  = '0;
      period_next   = '0;
      timeout_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Anything before the first rise is a partial phase; ignore it.
          if (rise) begin
            hi_next    = ONE;
            state_next = HIGH;
          end
        end

        HIGH: begin
          if (fall) begin
            lo_next    = ONE;
            state_next = LOW;
          end else if (sig_in) begin
            if (hi == LIMIT) begin
              timeout_next = 1'b1;
              hi_next      = '0;
              lo_next      = '0;
              state_next   = IDLE;
            end else begin
              hi_next = hi + ONE;
            end
          end
        end

        LOW: begin
          if (rise) begin
            high_cnt_next   = hi;
            low_cnt_next    = lo;
            period_next     = {1'b0, hi} + {1'b0, lo};
            meas_valid_next = 1'b1;
            // The closing rise is also the first high sample of the next cycle.
            hi_next         = ONE;
            lo_next         = '0;
            state_next      = HIGH;
          end else if (!sig_in) begin
            if (lo == LIMIT) begin
              timeout_next = 1'b1;
              hi_next      = '0;
              lo_next      = '0;
              state_next   = IDLE;
            end else begin
              lo_next = lo + ONE;
            end
          end
        end

        default: begin
          state_next = IDLE;
          hi_next    = '0;
          lo_next    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter. The stimulus pushes the expected
// measurement (values and strobe cycle) whenever it drives a rise that closes
// a full cycle; a monitor pops and compares on every meas_valid strobe.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int W = CNT_W_DEFAULT;

  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] l;
    logic [W:0]   p;
    int           c;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sig_in;
  logic         clear;
  logic         meas_valid;
  logic [W-1:0] high_cnt;
  logic [W-1:0] low_cnt;
  logic [W:0]   period;
  logic         timeout;

  int           cyc = 0;
  int           pass_cnt = 0;
  int           fail_cnt = 0;
  int           total_cnt = 0;

  exp_t         sb[$];
  logic         open_p;
  logic [W-1:0] open_h;
  logic [W-1:0] open_l;

  period_meter #(.CNT_W(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .clear      (clear),
    .meas_valid (meas_valid),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period     (period),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each iteration drives one sample; returns 1 time unit after the edge.
  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  // Called just before driving a rise: if a full cycle is open, the rise
  // closes it and the strobe must appear after the next edge.
  task automatic rise_push();
    exp_t e;
    if (open_p) begin
      e.h = open_h;
      e.l = open_l;
      e.p = {1'b0, open_h} + {1'b0, open_l};
      e.c = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic run_wave(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      rise_push();
      open_p = 1'b1;
      open_h = W'(h);
      open_l = W'(l);
      drive_level(1'b1, h);
      drive_level(1'b0, l);
    end
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0;
    sig_in  = 1'b1;
    clear   = 1'b0;
    open_p  = 1'b0;
    open_h  = '0;
    open_l  = '0;

    fork
      forever begin
        @(negedge clk);
        if (meas_valid === 1'b1) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", 32'(meas_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            $display("meas cyc=%0d high=%0d low=%0d period=%0d", cyc, high_cnt, low_cnt, period);
            check("valid_cycle", cyc, e.c);
            check("high_cnt", 32'(high_cnt), 32'(e.h));
            check("low_cnt", 32'(low_cnt), 32'(e.l));
            check("period", 32'(period), 32'(e.p));
          end
        end else if (sb.size() > 0 && sb[0].c < cyc) begin
          e = sb.pop_front();
          check("missing_valid", 32'(meas_valid), 32'd1);
        end
      end
    join_none

    // Reset with sig_in held high, then release with sig_in still high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_high", 32'(high_cnt), 32'd0);
    check("rst_low", 32'(low_cnt), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset_n = 1'b1;
    // A rise here would end in timeout after 256 samples; IDLE must hold.
    drive_level(1'b1, 270);
    check("stuck_high_no_timeout", 32'(timeout), 32'd0);
    check("stuck_high_no_meas", 32'(high_cnt), 32'd0);

    // div=3: 2 high / 2 low.
    drive_level(1'b0, 2);
    run_wave(2, 2, 6);
    // div=4: 2 high / 3 low.
    run_wave(2, 3, 5);
    // div=1: 1 high / 1 low.
    run_wave(1, 1, 6);

    // Timeout: rise then hold high for 300 samples.
    rise_push();
    open_p = 1'b0;
    drive_level(1'b1, 255);
    check("timeout_at_255", 32'(timeout), 32'd0);
    drive_level(1'b1, 1);
    check("timeout_at_256", 32'(timeout), 32'd1);
    drive_level(1'b1, 44);
    check("timeout_sticky_high", 32'(timeout), 32'd1);
    drive_level(1'b0, 2);
    run_wave(2, 2, 4);
    check("timeout_sticky_toggle", 32'(timeout), 32'd1);

    // Clear coinciding with the rise that would close a 2/2 cycle.
    clear  = 1'b1;
    open_p = 1'b0;
    drive_level(1'b1, 1);
    clear = 1'b0;
    check("clr_valid", 32'(meas_valid), 32'd0);
    check("clr_high", 32'(high_cnt), 32'd0);
    check("clr_low", 32'(low_cnt), 32'd0);
    check("clr_period", 32'(period), 32'd0);
    check("clr_timeout", 32'(timeout), 32'd0);
    drive_level(1'b1, 1);
    drive_level(1'b0, 2);
    run_wave(2, 2, 3);

    // Reset in the middle of a cycle with sig_in high.
    reset_n = 1'b0;
    sig_in  = 1'b1;
    #1;
    check("midrst_high", 32'(high_cnt), 32'd0);
    check("midrst_period", 32'(period), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    open_p  = 1'b0;
    drive_level(1'b1, 5);
    check("midrst_no_meas", 32'(high_cnt), 32'd0);
    drive_level(1'b0, 2);
    run_wave(2, 2, 2);

    drive_level(1'b0, 3);
    check("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
